// File: rtl/median_window_3x3_gen.sv
// Streaming 3x3 window generator: two circular line buffers plus a column shift register.
// Optional `MEDIAN_WIN_COORD_EN adds registered window-centre coordinates (win_row, win_col).
module median_window_3x3_gen #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_W-1:0]     in_pixel,
    input  logic                  sof,
    output logic                  win_valid,
    output logic [9*DATA_W-1:0]   win,
    output logic                  frame_done
`ifdef MEDIAN_WIN_COORD_EN
    ,
    output logic [$clog2(IMG_H)-1:0] win_row,
    output logic [$clog2(IMG_W)-1:0] win_col
`endif
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic [CW-1:0]     cur_col;
    logic [RW-1:0]     cur_row;
    logic              last_col;
    logic              last_row;
    logic              emit;
    logic              frame_end;

    logic [DATA_W-1:0] lb_a [IMG_W];
    logic [DATA_W-1:0] lb_b [IMG_W];
    logic [DATA_W-1:0] tap_a;
    logic [DATA_W-1:0] tap_b;

    // Window columns: left_q is the oldest column, mid_q the next; rows indexed top to bottom.
    logic [DATA_W-1:0] left_q  [3];
    logic [DATA_W-1:0] mid_q   [3];
    logic [DATA_W-1:0] new_col [3];
    logic [9*DATA_W-1:0] next_win;

    // sof forces the current pixel to be treated as (0,0).
    always_comb begin
        cur_col   = sof ? '0 : col;
        cur_row   = sof ? '0 : row;
        last_col  = (cur_col == CW'(IMG_W - 1));
        last_row  = (cur_row == RW'(IMG_H - 1));
        emit      = in_valid && (cur_row >= RW'(2)) && (cur_col >= CW'(2));
        frame_end = last_row && last_col;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (in_valid) begin
            if (last_col) begin
                col <= '0;
                row <= last_row ? '0 : cur_row + RW'(1);
            end else begin
                col <= cur_col + CW'(1);
                row <= cur_row;
            end
        end else if (sof) begin
            col <= '0;
            row <= '0;
        end
    end

    assign tap_a = lb_a[cur_col];
    assign tap_b = lb_b[cur_col];

    // Line memory is intentionally unreset: rows 0 and 1 never produce a window.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            lb_b[cur_col] <= tap_a;
            lb_a[cur_col] <= in_pixel;
        end
    end

    always_comb begin
        new_col[0] = tap_b;
        new_col[1] = tap_a;
        new_col[2] = in_pixel;
        next_win   = '0;
        for (int unsigned r = 0; r < 3; r++) begin
            next_win[(r*3+0)*DATA_W +: DATA_W] = left_q[r];
            next_win[(r*3+1)*DATA_W +: DATA_W] = mid_q[r];
            next_win[(r*3+2)*DATA_W +: DATA_W] = new_col[r];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned r = 0; r < 3; r++) begin
                left_q[r] <= '0;
                mid_q[r]  <= '0;
            end
        end else if (in_valid) begin
            for (int unsigned r = 0; r < 3; r++) begin
                left_q[r] <= mid_q[r];
                mid_q[r]  <= new_col[r];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_valid  <= 1'b0;
            win        <= '0;
            frame_done <= 1'b0;
        end else begin
            win_valid  <= emit;
            frame_done <= emit && frame_end;
            if (emit) begin
                win <= next_win;
            end
        end
    end

`ifdef MEDIAN_WIN_COORD_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_row <= '0;
            win_col <= '0;
        end else if (emit) begin
            win_row <= cur_row - RW'(1);
            win_col <= cur_col - CW'(1);
        end
    end
`endif

endmodule
